// File: rtl/shift_cmd_sequencer_if.sv
// Command, shifter and result signals of shift_cmd_sequencer.
// The slave modport is the sequencer's view; the master modport is its environment's view.
interface shift_cmd_sequencer_if #(
   parameter int CNT_W = 3
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [3:0]       cmd_data;
   logic [1:0]       cmd_amt;
   logic             cmd_dir;
   logic [3:0]       sh_data_in;
   logic [1:0]       sh_shift_amt;
   logic             sh_dir;
   logic [3:0]       sh_data_out;
   logic             res_valid;
   logic             res_ready;
   logic [3:0]       res_data;
   logic [CNT_W-1:0] fifo_count;

   modport master (
      output cmd_valid, cmd_data, cmd_amt, cmd_dir, res_ready, sh_data_out,
      input  cmd_ready, sh_data_in, sh_shift_amt, sh_dir, res_valid, res_data, fifo_count
   );

   modport slave (
      input  cmd_valid, cmd_data, cmd_amt, cmd_dir, res_ready, sh_data_out,
      output cmd_ready, sh_data_in, sh_shift_amt, sh_dir, res_valid, res_data, fifo_count
   );
endinterface

// File: rtl/shift_cmd_sequencer.sv
// Command FIFO in front of a combinational 4-bit barrel shifter, with a
// valid/ready result register that captures the shifter output.
module shift_cmd_sequencer #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   shift_cmd_sequencer_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);

   typedef struct packed {
      logic [3:0] data;
      logic [1:0] amt;
      logic       dir;
   } cmd_t;

   typedef enum logic {IDLE, VALID} state_e;

   cmd_t             fifo_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [3:0]       res_data_q, res_data_d;
   state_e           state_q, state_d;

   logic full, empty, push, pop;
   cmd_t head;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign push  = bus.cmd_valid & bus.cmd_ready;
   assign pop   = !empty & ((state_q == IDLE) | bus.res_ready);

   // An empty FIFO presents all-zero operands to the shifter.
   assign head = empty ? '0 : fifo_q[rd_ptr_q];

   assign bus.cmd_ready    = rst_n & !full;
   assign bus.sh_data_in   = head.data;
   assign bus.sh_shift_amt = head.amt;
   assign bus.sh_dir       = head.dir;
   assign bus.res_valid    = (state_q == VALID);
   assign bus.res_data     = res_data_q;
   assign bus.fifo_count   = count_q;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d    = state_q;
      res_data_d = res_data_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               state_d    = VALID;
               res_data_d = bus.sh_data_out;
            end
         end
         VALID: begin
            if (pop) begin
               res_data_d = bus.sh_data_out;
            end else if (bus.res_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         res_data_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         res_data_q <= res_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // NOTE: FIFO storage is deliberately not reset; count and pointers alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_q[wr_ptr_q] <= '{data: bus.cmd_data, amt: bus.cmd_amt, dir: bus.cmd_dir};
      end
   end
endmodule
